// File: rtl/mod_alu_operand_loader_if.sv
// Switch/button input bus and captured-operand output bus of the ALU
// operand loader.
//   SW        switch data: operand value or operation code
//   BTN_LOAD  raw load push-button (asynchronous, bouncy)
//   BTN_CLR   raw clear push-button (asynchronous, bouncy)
//   A_OUT     captured operand A
//   B_OUT     captured operand B
//   OP_OUT    captured operation code
//   VALID     high while A/B/OP form a complete operation
//   STATE     capture FSM state, for LEDs
// The slave modport is the loader; the master modport is the board or bench side.
interface mod_alu_operand_loader_if #(
  parameter int WIDTH = 6,
  parameter int OPW   = 4
);
  logic [WIDTH-1:0] SW;
  logic             BTN_LOAD;
  logic             BTN_CLR;
  logic [WIDTH-1:0] A_OUT;
  logic [WIDTH-1:0] B_OUT;
  logic [OPW-1:0]   OP_OUT;
  logic             VALID;
  logic [1:0]       STATE;

  modport master (
    output SW, BTN_LOAD, BTN_CLR,
    input  A_OUT, B_OUT, OP_OUT, VALID, STATE
  );

  modport slave (
    input  SW, BTN_LOAD, BTN_CLR,
    output A_OUT, B_OUT, OP_OUT, VALID, STATE
  );
endinterface

// File: rtl/mod_alu_operand_loader.sv
// ALU operand loader: captures operand A, operand B and the operation code
// from the switches, one debounced load-button press at a time, and holds
// them as registered inputs for the ALU datapath.
// Ports:
//   CLK  system clock, rising edge
//   RST  synchronous active-low reset
//   bus  slave side of mod_alu_operand_loader_if (SW, buttons in; A/B/OP,
//        VALID, STATE out). All outputs come straight from registers.
module mod_alu_operand_loader #(
  parameter int WIDTH     = 6,
  parameter int OPW       = 4,
  parameter int DB_CYCLES = 1000000
) (
  input  logic                        CLK,
  input  logic                        RST,
  mod_alu_operand_loader_if.slave     bus
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    WAIT_OP = 2'b10,
    EXEC    = 2'b11
  } state_t;

  // Button index 0 = load, 1 = clear.
  logic [1:0]    raw_s;
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    db_r;
  logic [1:0]    db_dly_r;
  logic [1:0]    evt_r;
  logic [CW-1:0] cnt_r [2];

  logic             load_evt_s;
  logic             clr_evt_s;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] b_s;
  logic [OPW-1:0]   op_r;
  logic [OPW-1:0]   op_s;
  logic             valid_r;

  assign raw_s      = {bus.BTN_CLR, bus.BTN_LOAD};
  assign load_evt_s = evt_r[0];
  assign clr_evt_s  = evt_r[1];

  // Two-stage synchronizer, debounce counters and registered rising-edge events.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_r  <= 2'b00;
      sync2_r  <= 2'b00;
      db_r     <= 2'b00;
      db_dly_r <= 2'b00;
      evt_r    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r  <= raw_s;
      sync2_r  <= sync1_r;
      db_dly_r <= db_r;
      // Only a rise of the debounced level is an event; releases are silent.
      evt_r    <= db_r & ~db_dly_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != db_r[i]) begin
          // Accept on the DB_CYCLES-th consecutive differing sample.
          if (cnt_r[i] == CNT_LAST) begin
            db_r[i]  <= sync2_r[i];
            cnt_r[i] <= '0;
          end else begin
            cnt_r[i] <= cnt_r[i] + CW'(1);
          end
        end else begin
          cnt_r[i] <= '0;
        end
      end
    end
  end

  // Capture FSM next state and next register values; clear beats load.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    op_s    = op_r;
    if (clr_evt_s) begin
      state_s = WAIT_A;
      a_s     = '0;
      b_s     = '0;
      op_s    = '0;
    end else if (load_evt_s) begin
      case (state_r)
        WAIT_A: begin
          a_s     = bus.SW;
          state_s = WAIT_B;
        end
        WAIT_B: begin
          b_s     = bus.SW;
          state_s = WAIT_OP;
        end
        WAIT_OP: begin
          op_s    = bus.SW[OPW-1:0];
          state_s = EXEC;
        end
        EXEC: begin
          // The press that leaves EXEC also recaptures A for the next operation.
          a_s     = bus.SW;
          state_s = WAIT_B;
        end
        default: begin
          state_s = WAIT_A;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers; VALID tracks the state being entered.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= WAIT_A;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      op_r    <= op_s;
      valid_r <= (state_s == EXEC);
    end
  end

  assign bus.A_OUT  = a_r;
  assign bus.B_OUT  = b_r;
  assign bus.OP_OUT = op_r;
  assign bus.VALID  = valid_r;
  assign bus.STATE  = state_r;

endmodule
